// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared funct3 codes, FSM encoding and decode helpers for the LSU.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5,
    ST_ERR    = 3'd6
  } lsu_state_e;

  function automatic logic lsu_funct3_ok(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_align
// Brief   : Combinational load lane extract/extend and store-lane merge.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{addr_lo, 3'b000} +: 8];
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data = {24'h0, w_byte};
      F3_H:    load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data = {16'h0, w_half};
      default: load_data = rdata;
    endcase
  end

  // Untouched lanes keep the word read back during the RMW read phase.
  always_comb begin
    merged = base;
    case (funct3[1:0])
      2'b00:   merged[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
      2'b01:   merged[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_master
// Brief   : RV32I load/store initiator for a word-only DMEM port; sub-word
//           stores via read-modify-write. Optional: LSU_MISALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        r_state, w_state_nxt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_merge_buf;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_bad;
  logic              w_rd_state;
  logic              w_wr_state;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_bad = !lsu_funct3_ok(req_we, req_funct3) ||
                 lsu_misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_bad = !lsu_funct3_ok(req_we, req_funct3);
`endif

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3    (r_funct3),
    .addr_lo   (r_addr[1:0]),
    .rdata     (mem_rdata),
    .base      (r_merge_buf),
    .wdata     (r_wdata),
    .load_data (w_load_data),
    .merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merge_buf <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
      end
      if (r_state == ST_LOAD)   r_rdata     <= w_load_data;
      if (r_state == ST_RMW_RD) r_merge_buf <= mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    w_rd_state  = 1'b0;
    w_wr_state  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_bad)                    w_state_nxt = ST_ERR;
          else if (!req_we)             w_state_nxt = ST_LOAD;
          else if (req_funct3 == F3_W)  w_state_nxt = ST_WRITE;
          else                          w_state_nxt = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        w_rd_state  = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RMW_RD: begin
        w_rd_state  = 1'b1;
        w_state_nxt = ST_RMW_WR;
      end
      ST_RMW_WR, ST_WRITE: begin
        w_wr_state  = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid  = 1'b1;
        resp_err    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Gating with rst keeps a reset edge from committing an in-flight write.
  assign mem_re     = w_rd_state && !rst;
  assign mem_we     = w_wr_state && !rst;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = w_wr_state ? w_merged : '0;
  assign resp_rdata = r_rdata;

  logic w_unused;
  assign w_unused = r_we;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_master
// Brief   : Directed self-checking bench for lsu_mem_master with a DMEM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [31:0] mem [0:15];
  logic        load_mem;
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          acc_cnt = 0;
  logic        both_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h01010101 * i;
      mem[4] <= 32'h8899AABB;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we && mem_re) both_seen <= 1'b1;
    if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    exp_t e;
    int   n;
    int   cyc;
    bit   seen;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 10) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_resp_seen"}, {31'b0, seen}, 32'd1);
    e = sb.pop_front();
    if (seen) begin
      chk({tag, "_latency"}, cyc, e.lat);
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
    end
  endtask

  initial begin
    int we0, re0, acc0, nresp;
    exp_t e;
    rst = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    load_mem = 1'b0;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req("lb",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    do_req("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2);
    do_req("lh",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2);
    do_req("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2);
    do_req("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2);

    we0 = we_cnt; re0 = re_cnt;
    do_req("sb", 1'b1, 3'b000, 32'h11, 32'h000000CC, 32'h0, 1'b0, 3);
    chk("sb_word4", mem[4], 32'h8899CCBB);
    chk("sb_word3", mem[3], 32'h03030303);
    chk("sb_word5", mem[5], 32'h05050505);
    chk("sb_writes", we_cnt - we0, 32'd1);
    chk("sb_reads", re_cnt - re0, 32'd1);

    do_req("sh", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, 3);
    chk("sh_word4", mem[4], 32'h1234CCBB);

    we0 = we_cnt; re0 = re_cnt;
    do_req("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_word4", mem[4], 32'hDEADBEEF);
    chk("sw_writes", we_cnt - we0, 32'd1);
    chk("sw_reads", re_cnt - re0, 32'd0);

    do_req("lb_neg",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2);
    do_req("lhu_low", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2);
    do_req("lb_pos",  1'b0, 3'b000, 32'h0D, 32'h0, 32'h00000003, 1'b0, 2);

    we0 = we_cnt; re0 = re_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
    do_req("lw_mis", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1);
    chk("lw_mis_reads", re_cnt - re0, 32'd0);
`else
    do_req("lw_mis", 1'b0, 3'b010, 32'h11, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    chk("lw_mis_reads", re_cnt - re0, 32'd1);
`endif
    chk("lw_mis_writes", we_cnt - we0, 32'd0);

    we0 = we_cnt; re0 = re_cnt;
    do_req("bad_ld_f3", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    do_req("bad_st_f3", 1'b1, 3'b100, 32'h10, 32'h000000AA, 32'h0, 1'b1, 1);
    chk("bad_writes", we_cnt - we0, 32'd0);
    chk("bad_reads", re_cnt - re0, 32'd0);
    chk("bad_word4", mem[4], 32'hDEADBEEF);

    // Reset asserted while the SB sits in its write phase.
    we0 = we_cnt;
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    nresp = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) nresp++;
    end
    chk("rstmid_no_resp", nresp, 32'd0);
    chk("rstmid_word4", mem[4], 32'hDEADBEEF);
    chk("rstmid_writes", we_cnt - we0, 32'd0);

    // req_valid held high: each request only accepted when req_ready.
    for (int k = 0; k < 3; k++) begin
      e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.lat = 2;
      sb.push_back(e);
    end
    acc0  = acc_cnt;
    nresp = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        nresp++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_rdata", resp_rdata, e.rdata);
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc_cnt - acc0, 32'd3);
    chk("b2b_resps", nresp, 32'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("never_we_and_re", {31'b0, both_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
